cpu_ad48: RTL and testbench
===========================

CPU_AD48 -- requirements
Module: cpu_ad48

Interface
REQ-001 SHALL have parameter IM_WORDS, default 128: instruction memory depth in 48-bit words.
REQ-002 SHALL have parameter DM_WORDS, default 32: data memory depth in 48-bit words.
REQ-003 SHALL have parameter TRAP_VECTOR, default 48'd64: PC loaded on every trap.
REQ-004 SHALL have parameter IRQ_LINES, default 4: number of interrupt request inputs.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port irq, input, IRQ_LINES bits: level-sensitive interrupt requests.
REQ-008 SHALL expose these hierarchical names for benches:
- pc, halt, handler_active
- csr_lr, csr_epc, csr_ssp, csr_scratch
- IMEM.mem[], DMEM.mem[]
- RF_A.regs[0..7], RF_D.regs[0..7]

Function
REQ-009 SHALL execute one 48-bit instruction per cycle, in order, from combinational IMEM.mem[pc]; next pc = pc+1 unless redirected.
REQ-010 SHALL take instruction encodings (opcodes, ALU subops, branch conditions, CSR functions, CSR addresses, field packing) from the shared cpu_ad48 instruction package.
- Immediate fields: 27-bit, sign-extended.
- Branch offsets: 31-bit, sign-extended.
REQ-011 ALUI_D/ALUI_A SHALL compute rd = rs OP imm, with OP in {ADD, SUB, AND, OR, XOR}, modulo 2^48, on the D or A register file.
REQ-012 BR SHALL test D[rs] against zero (BEQ, BNE, ...); when taken, pc = pc+1+off.
REQ-013 CSR_F_R SHALL copy the CSR to D[rd]; CSR_F_RW SHALL write D[rs] to the CSR and return the old value to D[rd].
- CSRs: SCRATCH, SSP, LR, EPC.
- Unknown CSR addresses: read 0, writes ignored.
REQ-014 SYS 0x1 (breakpoint) SHALL trap in one cycle:
- LR and EPC <= address of the SYS instruction.
- pc <= TRAP_VECTOR.
- depth <= depth+1.
REQ-015 SYS 0x2 (IRET) SHALL:
- set pc <= LR and EPC <= LR;
- decrement depth, saturating at 0;
- leave SSP unchanged.
REQ-016 SYS 0xF SHALL set halt=1 and freeze pc at the SYS address; no further state changes until reset. Other SYS codes are NOPs.
REQ-017 handler_active SHALL equal (depth != 0), with depth a 2-bit counter saturating at 3; traps SHALL nest.
REQ-018 While handler_active=1, every A7 read/write SHALL access csr_ssp; user RF_A.regs[7] SHALL remain unchanged.
REQ-019 Interrupts:
- When handler_active=0, halt=0 and any irq bit is 1, the core SHALL trap before executing the instruction at pc.
- LR/EPC <= pc (unexecuted instruction).
- Interrupts SHALL NOT be taken while handler_active=1.
- Breakpoint has priority over an irq in the same cycle.
REQ-020 LOAD/STORE SHALL address DMEM word-wise as A[rs]+imm modulo DM_WORDS; stores write synchronously.
REQ-021 The trap pc fetch SHALL wrap modulo IM_WORDS.

Reset
REQ-022 resetn low SHALL asynchronously clear:
- pc, halt, depth/handler_active;
- all CSRs;
- all RF_A/RF_D registers.
REQ-023 Reset SHALL NOT clear IMEM/DMEM, so benches can preload them during reset. Reset asserted mid-operation aborts immediately; execution restarts at pc=0 on the first edge after release.

Structure
REQ-024 Opcodes, subops, condition codes, CSR function/address codes, SYS codes and pack/encode functions SHALL live in the shared package/include cpu_ad48_instr.
REQ-025 One sub-module cpu_ad48_regfile (8x48, 2 read, 1 write) SHALL be instantiated as RF_A and RF_D. IMEM and DMEM are plain arrays named mem inside instances IMEM and DMEM.

Verification
REQ-026 Nested breakpoint test:
- Stimulus: SYS1 at 0; handler at 64 sets SSP=32, A7+=1, then SYS1 again; inner handler reads LR/SSP, A7+=1, sets LR to resume; both IRET; outer IRET to 1, then SYS F.
- Required response: pc=1, LR=EPC=1, SSP=34, D1=nested SYS address, D2=33, D5=34, scratch=0xAA, A7=0, handler_active=0.
REQ-027 ALU/branch: D1 = 0 ADD 5, then BNE D1 over a halt -> branch taken; D1=5 at a second halt.
REQ-028 IRQ: irq=4'b0010 in user mode -> pc=64, LR=interrupted pc, handler_active=1; irq held high inside the handler -> no re-trap.
REQ-029 Halt: SYS F at 3 -> halt=1, pc stays 3 for 10 further cycles.
REQ-030 Reset mid-run: resetn low while handler_active=1 -> pc=0, all CSRs=0, handler_active=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_ad48_instr.sv
// Shared instruction package for the cpu_ad48 core: encodings, field layout,
// pack helpers for benches and small decode/ALU helpers for the datapath.
//
// Field layout (48 bits):
//   [47:44] opcode   [43:41] rd   [40:38] rs   [37:34] sub/cond/fn
//   [33:31] zero     [30:0]  branch offset (31b) / immediate in [26:0] (27b)
//   CSR address lives in [11:0], SYS code in [3:0].
package cpu_ad48_instr;

  localparam int XLEN = 48;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ALUI_D = 4'h1,
    OP_ALUI_A = 4'h2,
    OP_BR     = 4'h3,
    OP_CSR    = 4'h4,
    OP_SYS    = 4'h5,
    OP_LOAD   = 4'h6,
    OP_STORE  = 4'h7
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_BEQ = 4'h0,
    BR_BNE = 4'h1,
    BR_BLT = 4'h2,
    BR_BGE = 4'h3,
    BR_BGT = 4'h4,
    BR_BLE = 4'h5,
    BR_BAL = 4'h6
  } br_cond_e;

  typedef enum logic [3:0] {
    CSR_F_R  = 4'h0,
    CSR_F_RW = 4'h1
  } csr_fn_e;

  localparam logic [11:0] CSR_SCRATCH = 12'h000;
  localparam logic [11:0] CSR_SSP     = 12'h001;
  localparam logic [11:0] CSR_LR      = 12'h002;
  localparam logic [11:0] CSR_EPC     = 12'h003;

  localparam logic [3:0] SYS_BRK  = 4'h1;
  localparam logic [3:0] SYS_IRET = 4'h2;
  localparam logic [3:0] SYS_HALT = 4'hF;

  function automatic logic [47:0] pack(logic [3:0] op, logic [2:0] rd, logic [2:0] rs,
                                       logic [3:0] fn, logic [30:0] low);
    return {op, rd, rs, fn, 3'b000, low};
  endfunction

  function automatic logic [47:0] enc_alu(opcode_e op, alu_op_e sub, logic [2:0] rd,
                                          logic [2:0] rs, logic [26:0] imm);
    return pack(op, rd, rs, sub, {4'b0000, imm});
  endfunction

  function automatic logic [47:0] enc_mem(opcode_e op, logic [2:0] rd, logic [2:0] rs,
                                          logic [26:0] imm);
    return pack(op, rd, rs, 4'h0, {4'b0000, imm});
  endfunction

  function automatic logic [47:0] enc_br(br_cond_e cond, logic [2:0] rs, logic [30:0] off);
    return pack(OP_BR, 3'd0, rs, cond, off);
  endfunction

  function automatic logic [47:0] enc_csr(csr_fn_e fn, logic [11:0] addr, logic [2:0] rd,
                                          logic [2:0] rs);
    return pack(OP_CSR, rd, rs, fn, {19'd0, addr});
  endfunction

  function automatic logic [47:0] enc_sys(logic [3:0] code);
    return pack(OP_SYS, 3'd0, 3'd0, 4'h0, {27'd0, code});
  endfunction

  // Unknown subops pass the register operand through unchanged.
  function automatic logic [47:0] alu(logic [3:0] sub, logic [47:0] a, logic [47:0] b);
    case (sub)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return a;
    endcase
  endfunction

  // Conditions compare a signed register value against zero.
  function automatic logic br_taken(logic [3:0] cond, logic [47:0] v);
    logic zero;
    logic neg;
    zero = (v == 48'd0);
    neg  = v[47];
    case (cond)
      BR_BEQ:  return zero;
      BR_BNE:  return !zero;
      BR_BLT:  return neg;
      BR_BGE:  return !neg;
      BR_BGT:  return !neg && !zero;
      BR_BLE:  return neg || zero;
      BR_BAL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ad48_regfile.sv
// 8 x 48-bit register file: two combinational read ports, one synchronous
// write port, asynchronously cleared.
module cpu_ad48_regfile
  import cpu_ad48_instr::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [2:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [2:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [8];

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  // Register write port with asynchronous clear of every entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/cpu_ad48.sv
// cpu_ad48: single-cycle 48-bit core with split D/A register files, CSRs,
// nested traps (breakpoint and level irq) and a shadow stack pointer that
// replaces A7 while a handler is active.
module cpu_ad48
  import cpu_ad48_instr::*;
#(
  parameter int          IM_WORDS    = 128,
  parameter int          DM_WORDS    = 32,
  parameter logic [47:0] TRAP_VECTOR = 48'd64,
  parameter int          IRQ_LINES   = 4
) (
  input logic                 clk,
  input logic                 resetn,
  input logic [IRQ_LINES-1:0] irq
);

  localparam int IW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
  localparam int DW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  logic [47:0] pc, csr_lr, csr_epc, csr_ssp, csr_scratch;
  logic        halt, handler_active;
  logic [1:0]  depth;

  logic [47:0] pc_n, lr_n, epc_n, ssp_n, scratch_n;
  logic        halt_n;
  logic [1:0]  depth_n;

  logic          dm_we;
  logic [DW-1:0] dm_idx;
  logic [47:0]   dm_rdata;
  logic [47:0]   d_rd1, d_rd2, a_rd1, a_rd2;

  // Instruction memory: contents come from outside (preloaded by benches).
  if (1) begin : IMEM
    logic [47:0] mem [IM_WORDS];
  end

  // Data memory with a synchronous store port; never reset so preloads survive.
  if (1) begin : DMEM
    logic [47:0] mem [DM_WORDS];
    // Store port: D[rd] written at the addressed word.
    always_ff @(posedge clk) begin
      if (dm_we) mem[dm_idx] <= d_rd2;
    end
  end

  // Fetch and decode.
  logic [IW-1:0] imem_idx;
  logic [47:0]   instr;
  opcode_e       op;
  logic [2:0]    rd, rs;
  logic [3:0]    sub;
  logic [11:0]   csr_addr;
  logic [3:0]    sys_code;
  logic [47:0]   simm, soff;

  assign imem_idx = IW'(pc % 48'(IM_WORDS));
  assign instr    = IMEM.mem[imem_idx];
  assign op       = opcode_e'(instr[47:44]);
  assign rd       = instr[43:41];
  assign rs       = instr[40:38];
  assign sub      = instr[37:34];
  assign csr_addr = instr[11:0];
  assign sys_code = instr[3:0];
  assign simm     = {{21{instr[26]}}, instr[26:0]};
  assign soff     = {{17{instr[30]}}, instr[30:0]};

  // A7 is redirected to the shadow stack pointer inside handlers.
  logic [47:0] a_src, alu_a, alu_d, csr_rdata;
  logic        is_brk, irq_take;

  assign handler_active = (depth != 2'd0);
  assign a_src    = (handler_active && rs == 3'd7) ? csr_ssp : a_rd1;
  assign alu_a    = alu(sub, a_src, simm);
  assign alu_d    = alu(sub, d_rd1, simm);
  assign dm_idx   = DW'((a_src + simm) % 48'(DM_WORDS));
  assign dm_rdata = DMEM.mem[dm_idx];
  assign is_brk   = (op == OP_SYS) && (sys_code == SYS_BRK);
  assign irq_take = (|irq) && !handler_active;

  logic d_we, a_we;
  logic [47:0] d_wd;

  cpu_ad48_regfile RF_D (
    .clk(clk), .resetn(resetn),
    .ra1(rs), .rd1(d_rd1), .ra2(rd), .rd2(d_rd2),
    .we(d_we), .wa(rd), .wd(d_wd)
  );

  cpu_ad48_regfile RF_A (
    .clk(clk), .resetn(resetn),
    .ra1(rs), .rd1(a_rd1), .ra2(rd), .rd2(a_rd2),
    .we(a_we), .wa(rd), .wd(alu_a)
  );

  // CSR read mux; unknown addresses read as zero.
  always_comb begin
    case (csr_addr)
      CSR_SCRATCH: csr_rdata = csr_scratch;
      CSR_SSP:     csr_rdata = csr_ssp;
      CSR_LR:      csr_rdata = csr_lr;
      CSR_EPC:     csr_rdata = csr_epc;
      default:     csr_rdata = 48'd0;
    endcase
  end

  // Next-state logic: halt freezes everything, breakpoint beats irq,
  // otherwise the instruction at pc executes.
  always_comb begin
    pc_n      = pc + 48'd1;
    halt_n    = halt;
    depth_n   = depth;
    lr_n      = csr_lr;
    epc_n     = csr_epc;
    ssp_n     = csr_ssp;
    scratch_n = csr_scratch;
    d_we      = 1'b0;
    d_wd      = 48'd0;
    a_we      = 1'b0;
    dm_we     = 1'b0;
    if (halt) begin
      pc_n = pc;
    end else if (is_brk || irq_take) begin
      lr_n    = pc;
      epc_n   = pc;
      pc_n    = TRAP_VECTOR;
      depth_n = (depth == 2'd3) ? 2'd3 : depth + 2'd1;
    end else begin
      case (op)
        OP_ALUI_D: begin
          d_we = 1'b1;
          d_wd = alu_d;
        end
        OP_ALUI_A: begin
          if (handler_active && rd == 3'd7) ssp_n = alu_a;
          else                              a_we  = 1'b1;
        end
        OP_BR: begin
          if (br_taken(sub, d_rd1)) pc_n = pc + 48'd1 + soff;
        end
        OP_CSR: begin
          if (sub == CSR_F_R || sub == CSR_F_RW) begin
            d_we = 1'b1;
            d_wd = csr_rdata;
          end
          if (sub == CSR_F_RW) begin
            case (csr_addr)
              CSR_SCRATCH: scratch_n = d_rd1;
              CSR_SSP:     ssp_n     = d_rd1;
              CSR_LR:      lr_n      = d_rd1;
              CSR_EPC:     epc_n     = d_rd1;
              default:     ;
            endcase
          end
        end
        OP_SYS: begin
          case (sys_code)
            SYS_IRET: begin
              pc_n    = csr_lr;
              epc_n   = csr_lr;
              depth_n = (depth == 2'd0) ? 2'd0 : depth - 2'd1;
            end
            SYS_HALT: begin
              halt_n = 1'b1;
              pc_n   = pc;
            end
            default: ;
          endcase
        end
        OP_LOAD: begin
          d_we = 1'b1;
          d_wd = dm_rdata;
        end
        OP_STORE: dm_we = 1'b1;
        default: ;
      endcase
    end
  end

  // Architectural state registers, asynchronously cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= 48'd0;
      halt        <= 1'b0;
      depth       <= 2'd0;
      csr_lr      <= 48'd0;
      csr_epc     <= 48'd0;
      csr_ssp     <= 48'd0;
      csr_scratch <= 48'd0;
    end else begin
      pc          <= pc_n;
      halt        <= halt_n;
      depth       <= depth_n;
      csr_lr      <= lr_n;
      csr_epc     <= epc_n;
      csr_ssp     <= ssp_n;
      csr_scratch <= scratch_n;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, a_rd2, instr[33:31]};

endmodule

// File: tb/tb_cpu_ad48.sv
// Bench for cpu_ad48: directed programs, expected values queued by the
// driver and checked by a negedge monitor.
module tb_cpu_ad48;
  import cpu_ad48_instr::*;

  localparam int IMW = 128;

  // Clock and reset
  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic [3:0] irq    = 4'b0000;

  cpu_ad48 dut (
    .clk(clk),
    .resetn(resetn),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Scoreboard
  logic [47:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  localparam int S_PC = 0, S_HALT = 1, S_HA = 2, S_LR = 3, S_EPC = 4, S_SSP = 5, S_SCR = 6;
  localparam int S_D = 8, S_A = 16;

  function automatic logic [47:0] probe(int sel);
    case (sel)
      S_PC:    return dut.pc;
      S_HALT:  return {47'd0, dut.halt};
      S_HA:    return {47'd0, dut.handler_active};
      S_LR:    return dut.csr_lr;
      S_EPC:   return dut.csr_epc;
      S_SSP:   return dut.csr_ssp;
      S_SCR:   return dut.csr_scratch;
      S_D + 0: return dut.RF_D.regs[0];
      S_D + 1: return dut.RF_D.regs[1];
      S_D + 2: return dut.RF_D.regs[2];
      S_D + 3: return dut.RF_D.regs[3];
      S_D + 4: return dut.RF_D.regs[4];
      S_D + 5: return dut.RF_D.regs[5];
      S_D + 6: return dut.RF_D.regs[6];
      S_D + 7: return dut.RF_D.regs[7];
      S_A + 1: return dut.RF_A.regs[1];
      S_A + 2: return dut.RF_A.regs[2];
      S_A + 7: return dut.RF_A.regs[7];
      default: return 48'hDEAD_DEAD_DEAD;
    endcase
  endfunction

  // Monitor: sample every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [47:0] e;
      logic [47:0] a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = probe(s);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got 0x%h expected 0x%h", n, a, e);
      end
    end
  end

  // Driver tasks
  task automatic chk(string name, int sel, logic [47:0] val);
    name_q.push_back(name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d checks left unsampled, expected 0", exp_q.size());
      exp_q.delete();
      sel_q.delete();
      name_q.delete();
    end
  endtask

  task automatic start();
    resetn = 1'b0;
    irq    = 4'b0000;
    for (int i = 0; i < IMW; i++) dut.IMEM.mem[i] = 48'd0;
    repeat (2) @(posedge clk);
  endtask

  task automatic go();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic ld(int addr, logic [47:0] w);
    dut.IMEM.mem[addr] = w;
  endtask

  task automatic wait_halt(string name, int budget);
    for (int i = 0; i < budget && !dut.halt; i++) @(negedge clk);
    tests_run++;
    if (!dut.halt) begin
      tests_failed++;
      $display("FAIL %s: halt=0 after %0d cycles, expected halt=1", name, budget);
    end
  endtask

  initial begin
    #1;
    // Reset state
    start();
    chk("rst_pc", S_PC, 48'd0);
    chk("rst_halt", S_HALT, 48'd0);
    chk("rst_ha", S_HA, 48'd0);
    chk("rst_lr", S_LR, 48'd0);
    chk("rst_ssp", S_SSP, 48'd0);
    chk("rst_d1", S_D + 1, 48'd0);
    drain();

    // Nested breakpoints with shadow stack pointer
    start();
    ld(0,  enc_sys(SYS_BRK));
    ld(1,  enc_sys(SYS_HALT));
    ld(64, enc_csr(CSR_F_R, CSR_SCRATCH, 3'd4, 3'd0));
    ld(65, enc_br(BR_BNE, 3'd4, 31'd14));
    ld(66, enc_alu(OP_ALUI_D, ALU_ADD, 3'd3, 3'd0, 27'd32));
    ld(67, enc_csr(CSR_F_RW, CSR_SSP, 3'd6, 3'd3));
    ld(68, enc_alu(OP_ALUI_A, ALU_ADD, 3'd7, 3'd7, 27'd1));
    ld(69, enc_alu(OP_ALUI_D, ALU_ADD, 3'd4, 3'd0, 27'hAA));
    ld(70, enc_csr(CSR_F_RW, CSR_SCRATCH, 3'd6, 3'd4));
    ld(71, enc_sys(SYS_BRK));
    ld(72, enc_alu(OP_ALUI_D, ALU_ADD, 3'd7, 3'd0, 27'd1));
    ld(73, enc_csr(CSR_F_RW, CSR_LR, 3'd6, 3'd7));
    ld(74, enc_sys(SYS_IRET));
    ld(80, enc_csr(CSR_F_R, CSR_LR, 3'd1, 3'd0));
    ld(81, enc_csr(CSR_F_R, CSR_SSP, 3'd2, 3'd0));
    ld(82, enc_alu(OP_ALUI_A, ALU_ADD, 3'd7, 3'd7, 27'd1));
    ld(83, enc_csr(CSR_F_R, CSR_SSP, 3'd5, 3'd0));
    ld(84, enc_alu(OP_ALUI_D, ALU_ADD, 3'd7, 3'd0, 27'd72));
    ld(85, enc_csr(CSR_F_RW, CSR_LR, 3'd6, 3'd7));
    ld(86, enc_sys(SYS_IRET));
    go();
    wait_halt("nest_halt", 200);
    chk("nest_pc", S_PC, 48'd1);
    chk("nest_lr", S_LR, 48'd1);
    chk("nest_epc", S_EPC, 48'd1);
    chk("nest_ssp", S_SSP, 48'd34);
    chk("nest_d1", S_D + 1, 48'd71);
    chk("nest_d2", S_D + 2, 48'd33);
    chk("nest_d5", S_D + 5, 48'd34);
    chk("nest_scratch", S_SCR, 48'hAA);
    chk("nest_a7", S_A + 7, 48'd0);
    chk("nest_ha", S_HA, 48'd0);
    drain();

    // ALU ops, branches, load/store with address wrap
    start();
    ld(0,  enc_alu(OP_ALUI_D, ALU_ADD, 3'd1, 3'd0, 27'd5));
    ld(1,  enc_alu(OP_ALUI_D, ALU_SUB, 3'd2, 3'd1, 27'd7));
    ld(2,  enc_alu(OP_ALUI_D, ALU_AND, 3'd3, 3'd2, 27'h0F0));
    ld(3,  enc_alu(OP_ALUI_D, ALU_OR,  3'd4, 3'd3, 27'h105));
    ld(4,  enc_alu(OP_ALUI_D, ALU_XOR, 3'd4, 3'd4, 27'h00F));
    ld(5,  enc_alu(OP_ALUI_A, ALU_ADD, 3'd2, 3'd0, 27'h7FF_FFFF));
    ld(6,  enc_br(BR_BNE, 3'd1, 31'd1));
    ld(7,  enc_sys(SYS_HALT));
    ld(8,  enc_br(BR_BEQ, 3'd1, 31'd1));
    ld(9,  enc_mem(OP_STORE, 3'd4, 3'd0, 27'd3));
    ld(10, enc_mem(OP_LOAD, 3'd6, 3'd2, 27'd4));
    ld(11, enc_sys(SYS_HALT));
    go();
    wait_halt("alu_halt", 100);
    chk("alu_pc", S_PC, 48'd11);
    chk("alu_add", S_D + 1, 48'd5);
    chk("alu_sub", S_D + 2, 48'hFFFF_FFFF_FFFE);
    chk("alu_and", S_D + 3, 48'h0F0);
    chk("alu_or_xor", S_D + 4, 48'h1FA);
    chk("alu_a_neg", S_A + 2, 48'hFFFF_FFFF_FFFF);
    chk("ld_wrap", S_D + 6, 48'h1FA);
    drain();

    // Interrupt taken in user mode, not re-taken inside the handler
    start();
    go();
    repeat (5) @(posedge clk);
    @(negedge clk);
    irq = 4'b0010;
    @(posedge clk);
    chk("irq_pc", S_PC, 48'd64);
    chk("irq_lr", S_LR, 48'd5);
    chk("irq_epc", S_EPC, 48'd5);
    chk("irq_ha", S_HA, 48'd1);
    drain();
    repeat (6) @(posedge clk);
    chk("irq_hold_pc", S_PC, 48'd70);
    chk("irq_hold_lr", S_LR, 48'd5);
    drain();

    // Halt freezes pc
    start();
    ld(3, enc_sys(SYS_HALT));
    go();
    wait_halt("halt_wait", 50);
    chk("halt_pc", S_PC, 48'd3);
    drain();
    repeat (10) @(posedge clk);
    chk("halt_pc_10", S_PC, 48'd3);
    chk("halt_flag", S_HALT, 48'd1);
    drain();

    // Asynchronous reset while inside a handler
    start();
    ld(3,  enc_sys(SYS_BRK));
    ld(64, enc_alu(OP_ALUI_D, ALU_ADD, 3'd3, 3'd0, 27'd9));
    ld(65, enc_csr(CSR_F_RW, CSR_SSP, 3'd6, 3'd3));
    ld(66, enc_alu(OP_ALUI_A, ALU_ADD, 3'd1, 3'd0, 27'd7));
    go();
    repeat (10) @(posedge clk);
    chk("pre_ha", S_HA, 48'd1);
    chk("pre_ssp", S_SSP, 48'd9);
    chk("pre_lr", S_LR, 48'd3);
    chk("pre_a1", S_A + 1, 48'd7);
    drain();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    chk("arst_pc", S_PC, 48'd0);
    chk("arst_ha", S_HA, 48'd0);
    chk("arst_lr", S_LR, 48'd0);
    chk("arst_epc", S_EPC, 48'd0);
    chk("arst_ssp", S_SSP, 48'd0);
    chk("arst_d3", S_D + 3, 48'd0);
    chk("arst_a1", S_A + 1, 48'd0);
    drain();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    chk("restart_pc", S_PC, 48'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
